// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI framing stage.
// Byte classes, framer states and the channel-message length helper.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHAN,
        SYSEX
    } state_t;

    localparam logic [7:0] ST_SYSEX    = 8'hF0;
    localparam logic [7:0] ST_EOX      = 8'hF7;
    localparam logic [7:0] ST_ACTSENSE = 8'hFE;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // Program change (Cx) and channel pressure (Dx) carry one data byte.
    function automatic logic [1:0] msg_len(input logic [3:0] kind);
        return (kind == 4'hC || kind == 4'hD) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_actsense_wdt.sv
// Active-sense silence watchdog, built only with MIDI_ACTIVE_SENSE_EN.
// Armed by the first FE, reloaded by every received byte.
module midi_actsense_wdt #(
    parameter int ACTSENSE_TO = 15_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_valid,
    input  logic arm,
    output logic timeout
);

    localparam int CW = $clog2(ACTSENSE_TO + 1);

    logic          armed;
    logic [CW-1:0] cnt;

    assign timeout = armed && !rx_valid
                  && (cnt == CW'(ACTSENSE_TO - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (rx_valid) begin
            cnt <= '0;
            if (arm) armed <= 1'b1;
        end else if (timeout) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (armed) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/midi_msg_framer.sv
// MIDI byte framer: running status, sysex tracking, real-time bypass.
// Define MIDI_ACTIVE_SENSE_EN to add the active-sense all-notes-off watchdog.
module midi_msg_framer
    import midi_pkg::*;
#(
    parameter int SYSEX_MAX   = 255,
    parameter int ACTSENSE_TO = 15_000_000
) (
    input  logic       reg_clk,
    input  logic       reset_reg,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [3:0] listen_ch,
    input  logic       omni,
    output logic       byteready,
    output logic [7:0] midibyte_nr,
    output logic [7:0] midi_in_data,
    output logic [3:0] midi_ch,
    output logic       is_cur_midi_ch,
    output logic       is_st_sysex,
    output logic       sysex_end,
    output logic       syx_overflow,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic       all_notes_off
);

    localparam logic [7:0] NR_MAX = 8'(SYSEX_MAX);

    state_t     state_q, state_d;
    logic [1:0] len_q, len_d;
    logic [7:0] nr_d, data_d, rtb_d, nr_inc;
    logic [3:0] ch_d;
    logic       cur_d, ovf_d, sx_d, br_d, end_d, rtv_d;
    logic       is_rt, is_sox, is_eox, is_sys, is_stat, is_data;
    logic       timeout;

`ifdef MIDI_ACTIVE_SENSE_EN
    midi_actsense_wdt #(
        .ACTSENSE_TO(ACTSENSE_TO)
    ) u_wdt (
        .clk     (reg_clk),
        .reset   (reset_reg),
        .rx_valid(rx_valid),
        .arm     (rx_valid && rx_data == ST_ACTSENSE),
        .timeout (timeout)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(ACTSENSE_TO);
    assign timeout    = 1'b0;
`endif

    assign is_rt   = rx_data >= RT_MIN;
    assign is_sox  = rx_data == ST_SYSEX;
    assign is_eox  = rx_data == ST_EOX;
    assign is_sys  = rx_data[7:4] == 4'hF && !is_rt && !is_sox && !is_eox;
    assign is_stat = rx_data[7] && rx_data[7:4] != 4'hF;
    assign is_data = !rx_data[7];

    assign nr_inc = (midibyte_nr == NR_MAX) ? NR_MAX : midibyte_nr + 8'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        nr_d    = midibyte_nr;
        data_d  = midi_in_data;
        ch_d    = midi_ch;
        cur_d   = is_cur_midi_ch;
        ovf_d   = syx_overflow;
        rtb_d   = rt_byte;
        br_d    = 1'b0;
        end_d   = 1'b0;
        rtv_d   = 1'b0;
        if (rx_valid) begin
            unique case (1'b1)
                is_rt: begin
                    rtv_d = 1'b1;
                    rtb_d = rx_data;
                end
                is_sox: begin
                    state_d = SYSEX;
                    ovf_d   = 1'b0;
                    br_d    = 1'b1;
                    nr_d    = 8'd0;
                    data_d  = rx_data;
                end
                is_eox: begin
                    if (state_q == SYSEX) begin
                        state_d = IDLE;
                        br_d    = 1'b1;
                        end_d   = 1'b1;
                        nr_d    = nr_inc;
                        data_d  = rx_data;
                    end
                end
                is_sys: state_d = IDLE;
                is_stat: begin
                    state_d = CHAN;
                    len_d   = msg_len(rx_data[7:4]);
                    ch_d    = rx_data[3:0];
                    br_d    = 1'b1;
                    nr_d    = 8'd0;
                    data_d  = rx_data;
                end
                is_data: begin
                    unique case (state_q)
                        CHAN: begin
                            br_d   = 1'b1;
                            data_d = rx_data;
                            nr_d   = (midibyte_nr == {6'd0, len_q})
                                   ? 8'd1 : midibyte_nr + 8'd1;
                        end
                        SYSEX: begin
                            br_d   = 1'b1;
                            data_d = rx_data;
                            nr_d   = nr_inc;
                            if (midibyte_nr == NR_MAX) ovf_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
        if (br_d) cur_d = (state_d == CHAN) && (omni || ch_d == listen_ch);
        sx_d = (state_d == SYSEX);
    end

    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            state_q        <= IDLE;
            len_q          <= 2'd0;
            byteready      <= 1'b0;
            midibyte_nr    <= 8'd0;
            midi_in_data   <= 8'd0;
            midi_ch        <= 4'd0;
            is_cur_midi_ch <= 1'b0;
            is_st_sysex    <= 1'b0;
            sysex_end      <= 1'b0;
            syx_overflow   <= 1'b0;
            rt_valid       <= 1'b0;
            rt_byte        <= 8'd0;
            all_notes_off  <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byteready      <= br_d;
            midibyte_nr    <= nr_d;
            midi_in_data   <= data_d;
            midi_ch        <= ch_d;
            is_cur_midi_ch <= cur_d;
            is_st_sysex    <= sx_d;
            sysex_end      <= end_d;
            syx_overflow   <= ovf_d;
            rt_valid       <= rtv_d;
            rt_byte        <= rtb_d;
            all_notes_off  <= timeout;
        end
    end

endmodule

// File: tb/tb_midi_msg_framer.sv
// Bench for midi_msg_framer: vector table, corner sequences, random vs model.
// Watchdog checks are active when built with MIDI_ACTIVE_SENSE_EN.
module tb_midi_msg_framer;

    localparam int TO   = 20;
    localparam int SMAX = 255;

    logic       clk = 1'b0;
    logic       reset_reg = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic [3:0] listen_ch = 4'd0;
    logic       omni = 1'b0;
    logic       byteready, is_cur_midi_ch, is_st_sysex, sysex_end;
    logic       syx_overflow, rt_valid, all_notes_off;
    logic [7:0] midibyte_nr, midi_in_data, rt_byte;
    logic [3:0] midi_ch;

    int total = 0;
    int bad   = 0;

    midi_msg_framer #(.SYSEX_MAX(SMAX), .ACTSENSE_TO(TO)) dut (
        .reg_clk       (clk),
        .reset_reg     (reset_reg),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .listen_ch     (listen_ch),
        .omni          (omni),
        .byteready     (byteready),
        .midibyte_nr   (midibyte_nr),
        .midi_in_data  (midi_in_data),
        .midi_ch       (midi_ch),
        .is_cur_midi_ch(is_cur_midi_ch),
        .is_st_sysex   (is_st_sysex),
        .sysex_end     (sysex_end),
        .syx_overflow  (syx_overflow),
        .rt_valid      (rt_valid),
        .rt_byte       (rt_byte),
        .all_notes_off (all_notes_off)
    );

    always #5 clk = ~clk;

    // Reference model: message-level bookkeeping (mode, data count since status).
    int         m_mode;  // 0 idle, 1 channel, 2 sysex
    int         m_k, m_len, m_idle;
    bit         m_armed;
    logic [7:0] e_nr, e_data, e_rtb;
    logic [3:0] e_ch;
    logic       e_cur, e_ovf, e_br, e_se, e_rtv, e_ano;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_len = 0; m_idle = 0; m_armed = 0;
        e_nr = 0; e_data = 0; e_rtb = 0; e_ch = 0;
        e_cur = 0; e_ovf = 0; e_br = 0; e_se = 0; e_rtv = 0; e_ano = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        int di;
        di = int'(d);
        e_br = 0; e_se = 0; e_rtv = 0; e_ano = 0;
        if (v) begin
            if (di >= 'hF8) begin
                e_rtv = 1; e_rtb = d;
`ifdef MIDI_ACTIVE_SENSE_EN
                if (di == 'hFE) m_armed = 1;
`endif
            end else if (di == 'hF0) begin
                m_mode = 2; m_k = 0; e_ovf = 0;
                e_br = 1; e_nr = 0; e_data = d;
            end else if (di == 'hF7) begin
                if (m_mode == 2) begin
                    e_br = 1; e_se = 1; e_data = d; m_mode = 0;
                    e_nr = 8'((m_k + 1 > SMAX) ? SMAX : m_k + 1);
                end
            end else if (di >= 'hF1) begin
                m_mode = 0;
            end else if (di >= 'h80) begin
                m_mode = 1; m_k = 0;
                m_len = (di / 16 == 12 || di / 16 == 13) ? 1 : 2;
                e_ch = 4'(di % 16); e_br = 1; e_nr = 0; e_data = d;
            end else if (m_mode == 1) begin
                m_k++;
                e_br = 1; e_data = d; e_nr = 8'(((m_k - 1) % m_len) + 1);
            end else if (m_mode == 2) begin
                m_k++;
                e_br = 1; e_data = d;
                e_nr = 8'((m_k > SMAX) ? SMAX : m_k);
                if (m_k > SMAX) e_ovf = 1;
            end
            m_idle = 0;
        end else if (m_armed) begin
            m_idle++;
            if (m_idle == TO) begin
                e_ano = 1; m_mode = 0; m_armed = 0; m_idle = 0;
            end
        end
        if (e_br) e_cur = (m_mode == 1) && (omni || e_ch == listen_ch);
    endtask

    task automatic chk_model();
        chk("br", byteready, e_br);
        chk("nr", midibyte_nr, e_nr);
        chk("data", midi_in_data, e_data);
        chk("ch", midi_ch, e_ch);
        chk("cur", is_cur_midi_ch, e_cur);
        chk("sx", is_st_sysex, m_mode == 2);
        chk("se", sysex_end, e_se);
        chk("ovf", syx_overflow, e_ovf);
        chk("rtv", rt_valid, e_rtv);
        chk("rtb", rt_byte, e_rtb);
        chk("ano", all_notes_off, e_ano);
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        model_step(v, d);
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_reg = 1'b1;
        rx_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_br", byteready, 0);
        chk("rst_nr", midibyte_nr, 0);
        chk("rst_data", midi_in_data, 0);
        chk("rst_ch", midi_ch, 0);
        chk("rst_cur", is_cur_midi_ch, 0);
        chk("rst_sx", is_st_sysex, 0);
        chk("rst_se", sysex_end, 0);
        chk("rst_ovf", syx_overflow, 0);
        chk("rst_rtv", rt_valid, 0);
        chk("rst_rtb", rt_byte, 0);
        chk("rst_ano", all_notes_off, 0);
        @(negedge clk);
        reset_reg = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] lch;
        logic       om;
        logic       br;
        logic [7:0] nr;
        logic [3:0] ch;
        logic       cur;
        logic       sx;
        logic       se;
        logic       rtv;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pulses, at;
        logic [7:0] b;

        // v, d, lch, omni | br, nr, ch, cur, sx, se, rtv
        tbl.push_back('{1, 8'h90, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h3C, 0, 0, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h64, 0, 0, 1, 2, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h90, 1, 0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'h3C, 1, 0, 1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'h64, 1, 0, 1, 2, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'h3E, 1, 0, 1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'h00, 1, 0, 1, 2, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'hC5, 5, 0, 1, 0, 5, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h07, 5, 0, 1, 1, 5, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h08, 5, 0, 1, 1, 5, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h90, 0, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 8'hF8, 0, 0, 0, 0, 0, 1, 0, 0, 1});
        tbl.push_back('{1, 8'h3C, 0, 0, 1, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h64, 0, 0, 1, 2, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 8'hF0, 0, 0, 1, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 8'h43, 0, 0, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 8'h10, 0, 0, 1, 2, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 8'hF7, 0, 0, 1, 3, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'hF7, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 8'h92, 7, 1, 1, 0, 2, 1, 0, 0, 0});
        tbl.push_back('{1, 8'hF3, 7, 1, 0, 0, 2, 1, 0, 0, 0});
        tbl.push_back('{1, 8'h3C, 7, 1, 0, 0, 2, 1, 0, 0, 0});
        tbl.push_back('{1, 8'hF0, 7, 1, 1, 0, 2, 0, 1, 0, 0});
        tbl.push_back('{1, 8'h55, 7, 1, 1, 1, 2, 0, 1, 0, 0});
        tbl.push_back('{1, 8'hF5, 7, 1, 0, 0, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 8'h55, 7, 1, 0, 0, 2, 0, 0, 0, 0});

        model_reset();
        do_reset();

        foreach (tbl[i]) begin
            listen_ch = tbl[i].lch;
            omni      = tbl[i].om;
            tick(tbl[i].v, tbl[i].d);
            chk($sformatf("v%0d_br", i), byteready, tbl[i].br);
            if (tbl[i].br) chk($sformatf("v%0d_nr", i), midibyte_nr, tbl[i].nr);
            if (tbl[i].br) chk($sformatf("v%0d_data", i), midi_in_data, tbl[i].d);
            chk($sformatf("v%0d_ch", i), midi_ch, tbl[i].ch);
            chk($sformatf("v%0d_cur", i), is_cur_midi_ch, tbl[i].cur);
            chk($sformatf("v%0d_sx", i), is_st_sysex, tbl[i].sx);
            chk($sformatf("v%0d_se", i), sysex_end, tbl[i].se);
            chk($sformatf("v%0d_rtv", i), rt_valid, tbl[i].rtv);
            if (tbl[i].rtv) chk($sformatf("v%0d_rtb", i), rt_byte, tbl[i].d);
        end

        // Long sysex: index saturates, overflow on the byte past the limit.
        listen_ch = 0; omni = 0;
        tick(1, 8'hF0);
        for (int i = 1; i <= 300; i++) begin
            tick(1, 8'h11);
            if (i == 254 || i == 255 || i == 256 || i == 300) begin
                chk("syx_nr", midibyte_nr, (i > 255) ? 255 : i);
                chk("syx_ovf", syx_overflow, i > 255);
            end
        end
        tick(1, 8'hF7);
        chk("eox_nr", midibyte_nr, 255);
        chk("eox_se", sysex_end, 1);
        chk("eox_ovf", syx_overflow, 1);
        tick(1, 8'hF0);
        chk("sox_ovf_clr", syx_overflow, 0);

        // Reset mid-message drops running status.
        tick(1, 8'h90);
        tick(1, 8'h3C);
        do_reset();
        tick(1, 8'h64);
        chk("post_rst_br", byteready, 0);

`ifdef MIDI_ACTIVE_SENSE_EN
        tick(1, 8'h90);
        tick(1, 8'h3C);
        tick(1, 8'hFE);
        pulses = 0; at = -1;
        for (int i = 1; i <= TO + 5; i++) begin
            tick(0, 8'h00);
            if (all_notes_off) begin
                pulses++;
                at = i;
            end
        end
        chk("as_pulses", pulses, 1);
        chk("as_at", at, TO);
        tick(1, 8'h64);
        chk("as_idle_br", byteready, 0);
        tick(1, 8'hFE);
        do_reset();
        pulses = 0;
        for (int i = 0; i < TO + 5; i++) begin
            tick(0, 8'h00);
            if (all_notes_off) pulses++;
        end
        chk("as_rst_disarm", pulses, 0);
`else
        tick(1, 8'hFE);
        chk("fe_rtv", rt_valid, 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 8'h00);
            if (all_notes_off) pulses++;
        end
        chk("ano_tied", pulses, 0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            if ($urandom_range(0, 99) < 5) begin
                listen_ch = 4'($urandom_range(0, 3));
                omni      = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 299) == 0)
                for (int j = 0; j < TO + 3; j++) tick(0, 8'h00);
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(0, 127));
            else if (r < 75) b = 8'($urandom_range(128, 239));
            else if (r < 80) b = 8'hF0;
            else if (r < 85) b = 8'hF7;
            else if (r < 90) b = 8'($urandom_range(241, 246));
            else             b = 8'($urandom_range(248, 255));
            tick($urandom_range(0, 9) < 7, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
